// File: rtl/golden_nonce_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : golden_nonce_uart_tx
// Description : Captures golden-nonce strobes into a small FIFO and sends each
//               nonce as 8N1 UART bytes, most significant byte first.
//               Build option GOLDEN_NONCE_SYNC_HDR_EN prefixes every nonce
//               with the sync byte 8'hA5.
// Revision    : 1.0 - initial release
// ============================================================================
module golden_nonce_uart_tx #(
  parameter int BAUD_DIV = 434,
  parameter int FIFO_AW  = 2
) (
  input  logic        hash_clk,
  input  logic        reset_n,
  input  logic        new_golden_nonce,
  input  logic [31:0] golden_nonce,
  output logic        uart_tx,
  output logic        busy,
  output logic        fifo_full,
  output logic [7:0]  drop_count
);

`ifdef GOLDEN_NONCE_SYNC_HDR_EN
  localparam int c_NBYTES = 5;
`else
  localparam int c_NBYTES = 4;
`endif
  localparam int          c_SR_W      = 8 * c_NBYTES;
  localparam int          c_DEPTH     = 2 ** FIFO_AW;
  localparam logic [15:0] c_BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  c_LAST_IDX  = 3'(c_NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Registered state
  state_t              r_state;
  logic [15:0]         r_baud;
  logic [2:0]          r_bit;
  logic [2:0]          r_idx;
  logic [c_SR_W-1:0]   r_sr;
  logic                r_tx;
  logic                r_busy;
  logic [FIFO_AW:0]    r_wr_ptr;
  logic [FIFO_AW:0]    r_rd_ptr;
  logic [7:0]          r_drop;
  logic [31:0]         r_mem [0:c_DEPTH-1];

  // Next-state values
  state_t              w_state_nxt;
  logic [15:0]         w_baud_nxt;
  logic [2:0]          w_bit_nxt;
  logic [2:0]          w_idx_nxt;
  logic [c_SR_W-1:0]   w_sr_nxt;
  logic                w_tx_nxt;
  logic                w_busy_nxt;
  logic [7:0]          w_cur_byte;
  logic                w_pop;

  // FIFO bookkeeping; pointers carry one extra wrap bit
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_tick;
  logic [FIFO_AW:0]    w_wr_nxt;
  logic [FIFO_AW:0]    w_rd_nxt;
  logic [7:0]          w_drop_nxt;
  logic [31:0]         w_head;
  logic [c_SR_W-1:0]   w_load;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                    (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  // A full FIFO still takes a nonce when the head leaves on the same edge
  assign w_push   = new_golden_nonce & (~w_full | w_pop);
  assign w_wr_nxt = r_wr_ptr + {{FIFO_AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd_ptr + {{FIFO_AW{1'b0}}, w_pop};
  assign w_drop_nxt = (new_golden_nonce && !w_push && (r_drop != 8'hFF)) ?
                      r_drop + 8'd1 : r_drop;
  assign w_tick   = (r_baud == c_BAUD_LAST);
  assign w_head   = r_mem[r_rd_ptr[FIFO_AW-1:0]];

`ifdef GOLDEN_NONCE_SYNC_HDR_EN
  assign w_load = {8'hA5, w_head};
`else
  assign w_load = w_head;
`endif

  // FIFO storage write; reset does not need to clear the array
  always_ff @(posedge hash_clk) begin
    if (reset_n && w_push) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= golden_nonce;
    end
  end

  // State register for FSM, bit timing, FIFO pointers and outputs
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_idx    <= '0;
      r_sr     <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_drop   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_idx    <= w_idx_nxt;
      r_sr     <= w_sr_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  // Next-state logic; the TX pin is computed from next state so it is a flop
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_sr_nxt    = r_sr;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    w_cur_byte  = '0;
    w_busy_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_idx_nxt   = '0;
          w_sr_nxt    = w_load;
        end
      end
      START: begin
        if (w_tick) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_baud_nxt = '0;
          if (r_idx != c_LAST_IDX) begin
            // Next byte follows immediately; the current byte is always the top one
            w_idx_nxt   = r_idx + 3'd1;
            w_sr_nxt    = r_sr << 8;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_cur_byte = w_sr_nxt[c_SR_W-1 -: 8];
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_cur_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE) || (w_wr_nxt != w_rd_nxt);
  end

  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign fifo_full  = w_full;
  assign drop_count = r_drop;

endmodule
`default_nettype wire
